// File: rtl/shot_pkg.sv
// Shared types and constants for the shot exchange (initiator and responder sides).
package shot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_COORD,
        WAIT_HDR,
        WAIT_RES,
        DONE
    } shot_state_t;

    localparam logic [7:0] HDR_SHOT_DEF = 8'hA5;
    localparam logic [7:0] HDR_RES_DEF  = 8'h5A;

    localparam logic [1:0] RES_MISS = 2'b11;
    localparam logic [1:0] RES_HIT  = 2'b10;
    localparam logic [1:0] RES_NONE = 2'b00;

    localparam logic [3:0] BOARD_MAX = 4'd9;

    // Row in [7:4], column in [3:0]; both must lie on the 10x10 board.
    function automatic logic coord_valid(input logic [7:0] coord);
        return (coord[7:4] <= BOARD_MAX) && (coord[3:0] <= BOARD_MAX);
    endfunction

    // A result byte is legal when the upper six bits are clear and the code is defined.
    function automatic logic result_legal(input logic [7:0] res);
        return (res[7:2] == 6'd0) &&
               ((res[1:0] == RES_MISS) || (res[1:0] == RES_HIT) || (res[1:0] == RES_NONE));
    endfunction

endpackage

// File: rtl/shot_initiator_if.sv
// Player-control and byte-link signals of the shot initiator.
// master = the initiator itself, slave = its environment (mouse control, link, board update).
interface shot_initiator_if;
    logic       fire;
    logic [7:0] target;
    logic       turn_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] msg_in;
    logic       result_valid;
    logic       busy;
    logic       err;

    modport master (
        input  fire, target, turn_en, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, msg_in, result_valid, busy, err
    );

    modport slave (
        output fire, target, turn_en, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, msg_in, result_valid, busy, err
    );
endinterface

// File: rtl/shot_timer.sv
// Saturating reply timer: cleared when the coordinate byte leaves, counts while enabled,
// and flags the terminal count TIMEOUT_CYCLES-1 (it never wraps).
module shot_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned     W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0]    TERM = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/shot_initiator.sv
// Shot initiator: sends the 2-byte shot frame, then waits for the 2-byte result frame.
// Build option: define SHOT_RETRY_EN to resend the frame up to MAX_RETRY times on timeout.
module shot_initiator
    import shot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65_000_000,
`ifdef SHOT_RETRY_EN
    parameter int unsigned MAX_RETRY      = 3,
`endif
    parameter logic [7:0]  HDR_SHOT       = HDR_SHOT_DEF,
    parameter logic [7:0]  HDR_RES        = HDR_RES_DEF
) (
    input logic              clk,
    input logic              rst,
    shot_initiator_if.master bus
);

    shot_state_t state, state_d;
    logic [7:0]  target_q;
    logic [1:0]  msg_q;
    logic        err_q;

    logic accept, waiting, res_seen, hdr_seen, timeout, retry_ok, give_up;
    logic timer_clear, expired;

    assign accept      = (state == IDLE) && bus.fire && bus.turn_en && coord_valid(bus.target);
    assign waiting     = (state == WAIT_HDR) || (state == WAIT_RES);
    assign res_seen    = (state == WAIT_RES) && bus.rx_valid;
    assign hdr_seen    = (state == WAIT_HDR) && bus.rx_valid && (bus.rx_data == HDR_RES);
    assign timer_clear = (state == SEND_COORD) && bus.tx_ready;
    // A result byte landing on the terminal-count cycle is accepted instead of timing out.
    assign timeout     = waiting && expired && !res_seen;
    assign give_up     = timeout && !retry_ok;

    shot_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (waiting),
        .expired(expired)
    );

`ifdef SHOT_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RETRY_W-1:0] retry_cnt;

    assign retry_ok = (retry_cnt < RETRY_W'(MAX_RETRY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (accept) begin
            retry_cnt <= '0;
        end else if (timeout && retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    // State register; reset forces IDLE, which drops tx_valid without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:       if (accept)       state_d = SEND_HDR;
            SEND_HDR:   if (bus.tx_ready) state_d = SEND_COORD;
            SEND_COORD: if (bus.tx_ready) state_d = WAIT_HDR;
            WAIT_HDR: begin
                if (timeout)       state_d = retry_ok ? SEND_HDR : DONE;
                else if (hdr_seen) state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (res_seen)     state_d = DONE;
                else if (timeout) state_d = retry_ok ? SEND_HDR : DONE;
            end
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid     = 1'b0;
        bus.tx_data      = 8'h00;
        bus.busy         = (state != IDLE);
        bus.result_valid = (state == DONE);
        unique case (state)
            SEND_HDR: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = HDR_SHOT;
            end
            SEND_COORD: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = target_q;
            end
            default: ;
        endcase
    end

    // msg_in and err persist across DONE so a once-per-frame consumer still sees the outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= 8'h00;
            msg_q    <= RES_NONE;
            err_q    <= 1'b0;
        end else if (accept) begin
            target_q <= bus.target;
            msg_q    <= RES_NONE;
            err_q    <= 1'b0;
        end else if (res_seen) begin
            if (result_legal(bus.rx_data)) begin
                msg_q <= bus.rx_data[1:0];
            end else begin
                msg_q <= RES_NONE;
                err_q <= 1'b1;
            end
        end else if (give_up) begin
            msg_q <= RES_NONE;
            err_q <= 1'b1;
        end
    end

    assign bus.msg_in = msg_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_shot_initiator.sv
// Self-checking bench for shot_initiator: acceptance/result table, multi-cycle corner
// sequences, and randomized frames checked against a frame-level model.
module tb_shot_initiator;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] tgt;
        logic       turn;
        logic [7:0] res;
        logic       acc;
        logic [1:0] msg;
        logic       err;
    } vec_t;

`ifdef SHOT_RETRY_EN
    localparam int RETRIES = 3;
`else
    localparam int RETRIES = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    int      cyc         = 0;
    int      last_hs_cyc = 0;
    int      rv_count    = 0;
    byte_q_t tx_log;

    logic [1:0] m_msg;
    logic       m_err;

    shot_initiator_if bus();

    shot_initiator #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Link-side monitor: records every transmitted byte and every result pulse.
    always @(posedge clk) begin
        cyc++;
        if (bus.tx_valid && bus.tx_ready) begin
            tx_log.push_back(bus.tx_data);
            last_hs_cyc = cyc;
        end
        if (bus.result_valid) rv_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [7:0] tx_at(input int i);
        return (tx_log.size() > i) ? tx_log[i] : 8'hxx;
    endfunction

    // Result-frame rules: the byte after the first 5A is the result; illegal -> err, msg 00.
    function automatic logic [2:0] model_result(input byte_q_t rsp);
        for (int i = 0; i + 1 < rsp.size(); i++) begin
            if (rsp[i] == 8'h5A) begin
                if (rsp[i+1] > 8'h03 || rsp[i+1] == 8'h01) return 3'b100;
                return {1'b0, rsp[i+1][1:0]};
            end
        end
        return 3'b100;
    endfunction

    task automatic send_rx(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic fire_shot(input logic [7:0] tgt, input logic turn);
        bus.target  = tgt;
        bus.turn_en = turn;
        bus.fire    = 1'b1;
        tick();
        bus.fire    = 1'b0;
    endtask

    // Wait for n transmitted bytes; while stalled, tx_valid/tx_data must hold.
    task automatic wait_tx(input int n, input bit rnd);
        int         k = 0;
        logic       pv, pr;
        logic [7:0] pd;
        while (tx_log.size() < n && k < 200) begin
            pv = bus.tx_valid;
            pd = bus.tx_data;
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            pr = bus.tx_ready;
            tick();
            k++;
            if (pv && !pr) begin
                check("tx_hold_valid", bus.tx_valid, 1'b1);
                check("tx_hold_data", bus.tx_data, pd);
            end
        end
        bus.tx_ready = 1'b1;
        check("tx_count", tx_log.size(), n);
    endtask

    task automatic wait_result(input int budget);
        int k = 0;
        while (!bus.result_valid && k < budget) begin
            tick();
            k++;
        end
        check("result_valid", bus.result_valid, 1'b1);
    endtask

    task automatic run_frame(input logic [7:0] tgt, input logic turn, input byte_q_t rsp,
                             input logic exp_acc, input logic [1:0] exp_msg,
                             input logic exp_err, input bit rnd);
        int rv0;
        tx_log.delete();
        rv0 = rv_count;
        bus.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        fire_shot(tgt, turn);
        check("accept_busy", bus.busy, exp_acc);
        if (exp_acc) begin
            check("accept_clears_err", bus.err, 1'b0);
            check("accept_clears_msg", bus.msg_in, 2'b00);
            wait_tx(2, rnd);
            check("tx_hdr", tx_at(0), 8'hA5);
            check("tx_coord", tx_at(1), tgt);
            foreach (rsp[i]) begin
                send_rx(rsp[i]);
                if (rnd && i + 1 < rsp.size()) repeat ($urandom_range(0, 1)) tick();
            end
            wait_result(40);
        end else begin
            check("reject_tx_valid", bus.tx_valid, 1'b0);
        end
        check("msg_in", bus.msg_in, exp_msg);
        check("err", bus.err, exp_err);
        tick();
        check("busy_end", bus.busy, 1'b0);
        check("result_pulses", rv_count - rv0, exp_acc);
    endtask

    vec_t    vecs[10];
    byte_q_t q;
    int      rv0;
    int      c0;

    initial begin
        vecs[0] = '{8'h37, 1'b1, 8'h02, 1'b1, 2'b10, 1'b0};
        vecs[1] = '{8'hA2, 1'b1, 8'h03, 1'b0, 2'b10, 1'b0};
        vecs[2] = '{8'h37, 1'b0, 8'h03, 1'b0, 2'b10, 1'b0};
        vecs[3] = '{8'h99, 1'b1, 8'h03, 1'b1, 2'b11, 1'b0};
        vecs[4] = '{8'h3A, 1'b1, 8'h02, 1'b0, 2'b11, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 8'h01, 1'b1, 2'b00, 1'b1};
        vecs[6] = '{8'h45, 1'b1, 8'h00, 1'b1, 2'b00, 1'b0};
        vecs[7] = '{8'h12, 1'b1, 8'h06, 1'b1, 2'b00, 1'b1};
        vecs[8] = '{8'hF0, 1'b1, 8'h02, 1'b0, 2'b00, 1'b1};
        vecs[9] = '{8'h90, 1'b1, 8'h02, 1'b1, 2'b10, 1'b0};

        rst          = 1'b1;
        bus.fire     = 1'b0;
        bus.target   = 8'h00;
        bus.turn_en  = 1'b0;
        bus.tx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_msg_in", bus.msg_in, 2'b00);
        check("rst_result_valid", bus.result_valid, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        tick();

        // Acceptance rules and result decoding
        for (int i = 0; i < 10; i++) begin
            q = '{8'h5A, vecs[i].res};
            run_frame(vecs[i].tgt, vecs[i].turn, q, vecs[i].acc, vecs[i].msg, vecs[i].err, 1'b0);
        end

        // Transmitter stalls 5 cycles on the header byte
        tx_log.delete();
        bus.tx_ready = 1'b0;
        fire_shot(8'h37, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", bus.tx_valid, 1'b1);
            check("stall_data", bus.tx_data, 8'hA5);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_tx(2, 1'b0);
        check("stall_tx_hdr", tx_at(0), 8'hA5);
        check("stall_tx_coord", tx_at(1), 8'h37);
        send_rx(8'h5A);
        send_rx(8'h03);
        wait_result(10);
        check("stall_msg", bus.msg_in, 2'b11);
        tick();

        // Garbage byte before the result header is discarded
        tx_log.delete();
        fire_shot(8'h37, 1'b1);
        wait_tx(2, 1'b0);
        send_rx(8'h11);
        check("garbage_busy", bus.busy, 1'b1);
        check("garbage_no_result", bus.result_valid, 1'b0);
        send_rx(8'h5A);
        send_rx(8'h03);
        wait_result(10);
        check("garbage_msg", bus.msg_in, 2'b11);
        check("garbage_err", bus.err, 1'b0);
        tick();

        // Fire while busy is dropped, not queued
        tx_log.delete();
        fire_shot(8'h37, 1'b1);
        wait_tx(2, 1'b0);
        fire_shot(8'h55, 1'b1);
        check("busy_fire_tx_valid", bus.tx_valid, 1'b0);
        send_rx(8'h5A);
        send_rx(8'h02);
        wait_result(10);
        check("busy_fire_msg", bus.msg_in, 2'b10);
        repeat (4) tick();
        check("busy_fire_tx_count", tx_log.size(), 2);
        check("busy_fire_idle", bus.busy, 1'b0);

        // Result byte on the terminal-count cycle wins over the timeout
        tx_log.delete();
        fire_shot(8'h44, 1'b1);
        wait_tx(2, 1'b0);
        c0 = last_hs_cyc;
        send_rx(8'h5A);
        while (cyc - c0 < 15) tick();
        send_rx(8'h02);
        check("edge_result_valid", bus.result_valid, 1'b1);
        check("edge_msg", bus.msg_in, 2'b10);
        check("edge_err", bus.err, 1'b0);
        check("edge_tx_count", tx_log.size(), 2);
        tick();

        // No reply: timeout (with resends when retry is built in)
        tx_log.delete();
        rv0 = rv_count;
        fire_shot(8'h37, 1'b1);
        begin
            int k = 0;
            while (!bus.result_valid && k < 400) begin
                check("to_no_early_err", bus.err, 1'b0);
                tick();
                k++;
            end
        end
        check("to_result_valid", bus.result_valid, 1'b1);
        check("to_err", bus.err, 1'b1);
        check("to_msg", bus.msg_in, 2'b00);
        check("to_latency", cyc - last_hs_cyc, 16);
        check("to_tx_count", tx_log.size(), 2 * (1 + RETRIES));
        for (int i = 0; i < 2 * (1 + RETRIES); i++) begin
            check("to_tx_byte", tx_at(i), (i % 2 == 0) ? 8'hA5 : 8'h37);
        end
        tick();
        check("to_busy_end", bus.busy, 1'b0);
        check("to_pulses", rv_count - rv0, 1);

        // Reset during SEND_COORD abandons the frame at once
        bus.tx_ready = 1'b0;
        fire_shot(8'h37, 1'b1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("pre_rst_valid", bus.tx_valid, 1'b1);
        check("pre_rst_data", bus.tx_data, 8'h37);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", bus.tx_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        tick();
        check("post_rst_tx_valid", bus.tx_valid, 1'b0);
        check("post_rst_msg", bus.msg_in, 2'b00);

        // Randomized frames against the frame-level model
        m_msg = 2'b00;
        m_err = 1'b0;
        for (int it = 0; it < 40; it++) begin
            logic [7:0] tgt;
            logic [7:0] b;
            logic       turn;
            logic       acc;
            logic [2:0] r;
            int         ng;
            tgt  = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            turn = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) begin
                send_rx(8'($urandom));
                check("idle_rx_busy", bus.busy, 1'b0);
                check("idle_rx_msg", bus.msg_in, m_msg);
            end
            q  = {};
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++) begin
                b = 8'($urandom);
                if (b == 8'h5A) b = 8'h00;
                q.push_back(b);
            end
            q.push_back(8'h5A);
            case ($urandom_range(0, 4))
                0:       q.push_back(8'h00);
                1:       q.push_back(8'h01);
                2:       q.push_back(8'h02);
                3:       q.push_back(8'h03);
                default: q.push_back(8'($urandom));
            endcase
            acc = turn && (tgt[7:4] <= 4'd9) && (tgt[3:0] <= 4'd9);
            if (acc) begin
                r     = model_result(q);
                m_err = r[2];
                m_msg = r[1:0];
            end
            run_frame(tgt, turn, q, acc, m_msg, m_err, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
